lb2x2_stream_ctrl: RTL and testbench

Frame sequencer for the 2x2 line buffer in the sparse-CNN front end. It accepts a raster pixel stream with a valid/ready handshake and drives the line buffer's `in_valid`/`data_in` as one gapless burst per frame. It tracks row and column position and emits a window-valid strobe, with coordinates, only when the buffer outputs form a legal 2x2 window, so no window ever spans a row wrap. It also reports frame completion and aborts a frame on an upstream gap.

---
 rtl/lb2x2_stream_ctrl_pkg.sv | 19 +
 rtl/lb2x2_stream_ctrl_if.sv | 39 +++
 rtl/lb2x2_stream_ctrl_pos_counter.sv | 51 +++++
 rtl/lb2x2_stream_ctrl.sv | 112 +++++++++++
 tb/tb_lb2x2_stream_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lb2x2_stream_ctrl_pkg.sv
// rtl/lb2x2_stream_ctrl_pkg.sv - shared state encoding and counter widths for the line buffer controllers
package lb_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        STREAM = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } lb_state_t;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W_DEFAULT = cnt_width(28);
    localparam int COL_W_DEFAULT = cnt_width(28);

endpackage

// File: rtl/lb2x2_stream_ctrl_if.sv
// rtl/lb2x2_stream_ctrl_if.sv - upstream pixel stream, line buffer drive and window/status bundle
interface lb2x2_stream_ctrl_if
    import lb_ctrl_pkg::*;
#(
    parameter int dataColNum = 28,
    parameter int dataRowNum = 28,
    parameter int wordlength = 16
);
    localparam int RW = cnt_width(dataRowNum);
    localparam int CW = cnt_width(dataColNum);

    logic                  frame_start;
    logic                  s_valid;
    logic [wordlength-1:0] s_data;
    logic                  s_ready;
    logic                  lb_in_valid;
    logic [wordlength-1:0] lb_data_in;
    logic                  win_valid;
    logic [RW-1:0]         win_row;
    logic [CW-1:0]         win_col;
    logic                  frame_done;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  frame_start, s_valid, s_data,
        output s_ready, lb_in_valid, lb_data_in,
               win_valid, win_row, win_col,
               frame_done, frame_err, busy
    );

    modport master (
        output frame_start, s_valid, s_data,
        input  s_ready, lb_in_valid, lb_data_in,
               win_valid, win_row, win_col,
               frame_done, frame_err, busy
    );

endinterface

// File: rtl/lb2x2_stream_ctrl_pos_counter.sv
// rtl/lb2x2_stream_ctrl_pos_counter.sv - raster row/col position counter with clear and last-pixel flag
module lb_pos_counter
    import lb_ctrl_pkg::*;
#(
    parameter int COLS = 28,
    parameter int ROWS = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_inc,
    output logic [cnt_width(ROWS)-1:0] o_row,
    output logic [cnt_width(COLS)-1:0] o_col,
    output logic                       o_last
);
    localparam int RW = cnt_width(ROWS);
    localparam int CW = cnt_width(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_col_wrap;
    logic          w_row_wrap;

    assign w_col_wrap = (r_col == COL_MAX);
    assign w_row_wrap = (r_row == ROW_MAX);

    // The final pixel wraps both counters so the row never runs past the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_inc) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_col_wrap & w_row_wrap;

endmodule

// File: rtl/lb2x2_stream_ctrl.sv
// rtl/lb2x2_stream_ctrl.sv - 2x2 line buffer frame sequencer and window qualifier
// LB_STRIDE2_EN: only odd-row/odd-col windows (non-overlapping stride-2 pattern)
module lb2x2_stream_ctrl
    import lb_ctrl_pkg::*;
#(
    parameter int dataColNum = 28,
    parameter int dataRowNum = 28,
    parameter int wordlength = 16
) (
    input  logic               clk,
    input  logic               irst,
    lb2x2_stream_ctrl_if.slave bus
);
    localparam int RW = cnt_width(dataRowNum);
    localparam int CW = cnt_width(dataColNum);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_ARMED  = ARMED;
    localparam logic [2:0] S_STREAM = STREAM;
    localparam logic [2:0] S_DONE   = DONE;
    localparam logic [2:0] S_ERR    = ERR;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_clr;
    logic                  w_last;
    logic                  w_win_ok;
    logic [RW-1:0]         w_row;
    logic [CW-1:0]         w_col;
    logic [wordlength-1:0] w_data;

    logic                  r_win_valid;
    logic [RW-1:0]         r_win_row;
    logic [CW-1:0]         r_win_col;

    assign w_ready  = (r_state == S_ARMED) || (r_state == S_STREAM);
    assign w_accept = bus.s_valid & w_ready;

    // Clear on entry to ARMED and on abort; a gap means the line buffer already emptied itself
    assign w_clr = ((r_state == S_IDLE) && bus.frame_start) ||
                   ((r_state == S_STREAM) && !bus.s_valid);

    lb_pos_counter #(
        .COLS (dataColNum),
        .ROWS (dataRowNum)
    ) u_pos (
        .clk    (clk),
        .rst    (irst),
        .i_clr  (w_clr),
        .i_inc  (w_accept),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.frame_start) w_next = S_ARMED;
            S_ARMED:  if (bus.s_valid) w_next = S_STREAM;
            S_STREAM: begin
                if (!bus.s_valid)
                    w_next = S_ERR;
                else if (w_last)
                    w_next = S_DONE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge irst) begin
        if (irst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

`ifdef LB_STRIDE2_EN
    assign w_win_ok = w_accept && (w_row != '0) && (w_col != '0) && w_row[0] && w_col[0];
`else
    assign w_win_ok = w_accept && (w_row != '0) && (w_col != '0);
`endif

    // Registered so the strobe lines up with the line buffer's one-cycle output delay
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            r_win_valid <= w_win_ok;
            if (w_win_ok) begin
                r_win_row <= w_row;
                r_win_col <= w_col;
            end
        end
    end

    assign w_data          = bus.s_data;
    assign bus.lb_data_in  = w_data;
    assign bus.s_ready     = w_ready;
    assign bus.lb_in_valid = w_accept;
    assign bus.win_valid   = r_win_valid;
    assign bus.win_row     = r_win_row;
    assign bus.win_col     = r_win_col;
    assign bus.frame_done  = (r_state == S_DONE);
    assign bus.frame_err   = (r_state == S_ERR);
    assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_lb2x2_stream_ctrl.sv
// tb/tb_lb2x2_stream_ctrl.sv - randomized self-checking bench for lb2x2_stream_ctrl (4x3 frame)
module tb_lb2x2_stream_ctrl;
    localparam int C = 4;
    localparam int R = 3;
    localparam int W = 16;
    localparam int N = R * C;

    typedef struct {
        bit fs, sv, rdy, lbv, win, done, err, busy;
        int wr, wc;
    } cyc_t;

    logic clk;
    logic irst;
    int   n_chk;
    int   n_fail;

    lb2x2_stream_ctrl_if #(.dataColNum(C), .dataRowNum(R), .wordlength(W)) bus ();

    lb2x2_stream_ctrl #(.dataColNum(C), .dataRowNum(R), .wordlength(W)) dut (
        .clk  (clk),
        .irst (irst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit qual(input int k);
        int r;
        int c;
        r = k / C;
        c = k % C;
`ifdef LB_STRIDE2_EN
        return (r >= 1) && (c >= 1) && (r % 2 == 1) && (c % 2 == 1);
`else
        return (r >= 1) && (c >= 1);
`endif
    endfunction

    function automatic int windows_per_frame();
`ifdef LB_STRIDE2_EN
        return (R / 2) * (C / 2);
`else
        return (R - 1) * (C - 1);
`endif
    endfunction

    // Builds the expected per-cycle behaviour of one frame, then drives and checks it.
    // Entered just after a rising edge with the controller idle.
    task automatic run_frame(input int armed_wait, input int npix, input bit mid_start,
                             output int wins_got);
        cyc_t c;
        cyc_t plan[$];
        logic [W-1:0] d;
        wins_got = 0;
        c = '{default: 0};
        c.fs = 1;
        plan.push_back(c);
        repeat (armed_wait) begin
            c = '{default: 0};
            c.rdy = 1; c.busy = 1;
            plan.push_back(c);
        end
        for (int k = 0; k < npix; k++) begin
            c = '{default: 0};
            c.sv = 1; c.rdy = 1; c.lbv = 1; c.busy = 1;
            c.fs = mid_start && (k == 6);
            if (k > 0 && qual(k - 1)) begin
                c.win = 1; c.wr = (k - 1) / C; c.wc = (k - 1) % C;
            end
            plan.push_back(c);
        end
        c = '{default: 0};
        c.busy = 1;
        if (qual(npix - 1)) begin
            c.win = 1; c.wr = (npix - 1) / C; c.wc = (npix - 1) % C;
        end
        if (npix < N) begin
            c.rdy = 1;
            plan.push_back(c);
            c = '{default: 0};
            c.err = 1; c.busy = 1;
        end else begin
            c.done = 1;
        end
        plan.push_back(c);
        c = '{default: 0};
        plan.push_back(c);

        foreach (plan[i]) begin
            d = W'($urandom);
            bus.frame_start = plan[i].fs;
            bus.s_valid     = plan[i].sv;
            bus.s_data      = d;
            @(negedge clk);
            n_chk += 7;
            if (bus.s_ready !== plan[i].rdy) begin
                n_fail++; $display("FAIL s_ready cyc%0d: got %b want %b", i, bus.s_ready, plan[i].rdy);
            end
            if (bus.lb_in_valid !== plan[i].lbv) begin
                n_fail++; $display("FAIL lb_in_valid cyc%0d: got %b want %b", i, bus.lb_in_valid, plan[i].lbv);
            end
            if (bus.win_valid !== plan[i].win) begin
                n_fail++; $display("FAIL win_valid cyc%0d: got %b want %b", i, bus.win_valid, plan[i].win);
            end
            if (bus.frame_done !== plan[i].done) begin
                n_fail++; $display("FAIL frame_done cyc%0d: got %b want %b", i, bus.frame_done, plan[i].done);
            end
            if (bus.frame_err !== plan[i].err) begin
                n_fail++; $display("FAIL frame_err cyc%0d: got %b want %b", i, bus.frame_err, plan[i].err);
            end
            if (bus.busy !== plan[i].busy) begin
                n_fail++; $display("FAIL busy cyc%0d: got %b want %b", i, bus.busy, plan[i].busy);
            end
            if (plan[i].lbv && bus.lb_data_in !== d) begin
                n_fail++; $display("FAIL lb_data_in cyc%0d: got %h want %h", i, bus.lb_data_in, d);
            end
            if (plan[i].win) begin
                n_chk++;
                if (int'(bus.win_row) != plan[i].wr || int'(bus.win_col) != plan[i].wc) begin
                    n_fail++;
                    $display("FAIL win_coord cyc%0d: got (%0d,%0d) want (%0d,%0d)",
                             i, bus.win_row, bus.win_col, plan[i].wr, plan[i].wc);
                end
            end
            if (bus.win_valid === 1'b1) wins_got++;
            @(posedge clk);
            #1;
        end
        bus.frame_start = 1'b0;
        bus.s_valid     = 1'b0;
    endtask

    task automatic test_reset();
        irst = 1'b1;
        bus.frame_start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        @(negedge clk);
        n_chk++;
        if ({bus.s_ready, bus.lb_in_valid, bus.win_valid, bus.frame_done, bus.frame_err, bus.busy,
             bus.win_row, bus.win_col} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b lbv=%b win=%b done=%b err=%b busy=%b row=%0d col=%0d want all 0",
                     bus.s_ready, bus.lb_in_valid, bus.win_valid, bus.frame_done, bus.frame_err,
                     bus.busy, bus.win_row, bus.win_col);
        end
        @(posedge clk);
        #1;
        irst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got busy=%b rdy=%b want 0 0", bus.busy, bus.s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clean_frame();
        int w;
        run_frame(0, N, 1'b0, w);
        n_chk++;
        if (w != windows_per_frame()) begin
            n_fail++; $display("FAIL clean_window_count: got %0d want %0d", w, windows_per_frame());
        end
    endtask

    task automatic test_gap_abort();
        int w;
        run_frame(0, 5, 1'b0, w);
        run_frame(0, N, 1'b0, w);
        n_chk++;
        if (w != windows_per_frame()) begin
            n_fail++; $display("FAIL after_gap_window_count: got %0d want %0d", w, windows_per_frame());
        end
    endtask

    task automatic test_armed_wait();
        int w;
        run_frame(10, N, 1'b0, w);
        n_chk++;
        if (w != windows_per_frame()) begin
            n_fail++; $display("FAIL armed_wait_window_count: got %0d want %0d", w, windows_per_frame());
        end
    endtask

    task automatic test_mid_start();
        int w;
        run_frame(0, N, 1'b1, w);
        n_chk++;
        if (w != windows_per_frame()) begin
            n_fail++; $display("FAIL mid_start_window_count: got %0d want %0d", w, windows_per_frame());
        end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = W'($urandom);
            @(posedge clk);
            #1;
        end
        bus.s_data = W'($urandom);
        irst = 1'b1;
        #1;
        n_chk++;
        if ({bus.s_ready, bus.lb_in_valid, bus.win_valid, bus.frame_done, bus.frame_err, bus.busy,
             bus.win_row, bus.win_col} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got rdy=%b lbv=%b win=%b done=%b err=%b busy=%b row=%0d col=%0d want all 0",
                     bus.s_ready, bus.lb_in_valid, bus.win_valid, bus.frame_done, bus.frame_err,
                     bus.busy, bus.win_row, bus.win_col);
        end
        @(posedge clk);
        #1;
        irst = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0 || bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b err=%b done=%b want 0 0 0",
                     bus.busy, bus.frame_err, bus.frame_done);
        end
        @(posedge clk);
        #1;
        run_frame(0, N, 1'b0, w);
        n_chk++;
        if (w != windows_per_frame()) begin
            n_fail++; $display("FAIL post_reset_window_count: got %0d want %0d", w, windows_per_frame());
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_clean_frame();
        test_gap_abort();
        test_armed_wait();
        test_mid_start();
        test_reset_mid_frame();
        test_clean_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
